// File: rtl/color_scan_sequencer.sv
// color_scan_sequencer
// Sequences one colour-analysis pass over the RGB332 frame buffer. After a CPU
// start pulse it waits for the camera to finish a frame. It then holds the
// camera writer off and reads every pixel address once through the shared read
// port. The VGA reader always wins the port. Pixels go to the classifier with
// first/last markers. Busy/done/timeout status goes to the CPU register block.
//
// Optional feature: define SCAN_TIMEOUT_EN to enable a watchdog. The watchdog
// aborts a pass that spends TIMEOUT_CYC cycles in WAIT_FRAME plus SCAN.
module color_scan_sequencer #(
  parameter int ADDR_W      = 32'sd15,
  parameter int NPIX        = 32'sd19200,
  parameter int BASE_ADDR   = 32'sd0,
  parameter int TIMEOUT_CYC = 32'sd1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cam_frame_done,
  output logic              cam_hold,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_grant,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              pix_first,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NPIX - 32'sd1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1'b1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              drain_r;
  logic              issue_s;
  logic              cnt_last_s;
  logic              in_watch_s;
  logic              wd_expire_s;
  logic [ADDR_W-1:0] fb_addr_s;

  logic              busy_r;
  logic              busy_nxt_s;
  logic              cam_hold_r;
  logic              cam_hold_nxt_s;
  logic              done_r;
  logic              done_nxt_s;
  logic              timeout_r;
  logic              timeout_nxt_s;

  logic              s1_valid_r;
  logic              s1_first_r;
  logic              s1_last_r;
  logic [7:0]        pix_data_r;
  logic              pix_valid_r;
  logic              pix_first_r;
  logic              pix_last_r;

  assign cnt_last_s = (cnt_r == LAST_CNT);
  assign in_watch_s = (state_r == ST_WAIT) || (state_r == ST_SCAN);

  // The analyser issues only on cycles the VGA reader leaves the read port free
  always_comb begin
    issue_s   = 1'b0;
    fb_addr_s = vga_addr;
    if ((state_r == ST_SCAN) && !vga_req) begin
      issue_s   = 1'b1;
      fb_addr_s = BASE + cnt_r;
    end else begin
      issue_s   = 1'b0;
      fb_addr_s = vga_addr;
    end
  end

  assign vga_grant = vga_req;
  assign fb_addr   = fb_addr_s;

`ifdef SCAN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 32'sd1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 32'sd1);

  logic [WD_W-1:0] wd_r;

  // Watchdog: counts cycles spent waiting for a frame or scanning, else restarts
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r <= {WD_W{1'b0}};
    end else if (in_watch_s) begin
      wd_r <= wd_r + WD_W'(1'b1);
    end else begin
      wd_r <= {WD_W{1'b0}};
    end
  end

  assign wd_expire_s = in_watch_s && (wd_r == WD_LAST);
`else
  // No watchdog: a pass waits for its frame and the read port indefinitely
  logic cfg_unused_s;
  assign cfg_unused_s = (TIMEOUT_CYC > 32'sd0);
  assign wd_expire_s  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a watchdog abort overrides normal progress
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wd_expire_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cam_frame_done) begin
          state_nxt_s = ST_SCAN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_SCAN: begin
        if (wd_expire_s) begin
          state_nxt_s = ST_IDLE;
        end else if (issue_s && cnt_last_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (drain_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Status outputs are derived from the upcoming state so they register cleanly
  always_comb begin
    busy_nxt_s     = 1'b0;
    cam_hold_nxt_s = 1'b0;
    done_nxt_s     = done_r;
    timeout_nxt_s  = timeout_r;
    case (state_nxt_s)
      ST_WAIT: begin
        busy_nxt_s     = 1'b1;
        cam_hold_nxt_s = 1'b0;
      end
      ST_SCAN, ST_DRAIN: begin
        busy_nxt_s     = 1'b1;
        cam_hold_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s     = 1'b0;
        cam_hold_nxt_s = 1'b0;
      end
    endcase
    if ((state_r == ST_IDLE) && start) begin
      done_nxt_s    = 1'b0;
      timeout_nxt_s = 1'b0;
    end else if (wd_expire_s) begin
      done_nxt_s    = done_r;
      timeout_nxt_s = 1'b1;
    end else if ((state_r == ST_DRAIN) && drain_r) begin
      done_nxt_s    = 1'b1;
      timeout_nxt_s = timeout_r;
    end else begin
      done_nxt_s    = done_r;
      timeout_nxt_s = timeout_r;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= 1'b0;
      cam_hold_r <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      cam_hold_r <= cam_hold_nxt_s;
      done_r     <= done_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // Pixel counter: cleared when the scan begins, advanced on every issue
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if ((state_r == ST_WAIT) && (state_nxt_s == ST_SCAN)) begin
      cnt_r <= CNT_ZERO;
    end else if (issue_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Two-cycle drain timer so the last pixel leaves the pipe before DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_r <= 1'b0;
    end else begin
      drain_r <= (state_r == ST_DRAIN) && !drain_r;
    end
  end

  // Stage 1: tag the issued address while the frame buffer fetches it
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end else begin
      s1_valid_r <= issue_s;
      s1_first_r <= issue_s && (cnt_r == CNT_ZERO);
      s1_last_r  <= issue_s && cnt_last_s && !wd_expire_s;
    end
  end

  // Stage 2: register the returned pixel and its markers for the classifier
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data_r  <= 8'd0;
      pix_valid_r <= 1'b0;
      pix_first_r <= 1'b0;
      pix_last_r  <= 1'b0;
    end else begin
      if (s1_valid_r) begin
        pix_data_r <= fb_data;
      end else begin
        pix_data_r <= pix_data_r;
      end
      pix_valid_r <= s1_valid_r;
      pix_first_r <= s1_valid_r && s1_first_r;
      pix_last_r  <= s1_valid_r && s1_last_r;
    end
  end

  assign pix_data  = pix_data_r;
  assign pix_valid = pix_valid_r;
  assign pix_first = pix_first_r;
  assign pix_last  = pix_last_r;
  assign busy      = busy_r;
  assign cam_hold  = cam_hold_r;
  assign done      = done_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Directed bench for color_scan_sequencer with a frame buffer model fb[i]=i[7:0].
module tb_color_scan_sequencer;
  localparam int ADDR_W = 15;
  localparam int NPIX   = 19200;
`ifdef SCAN_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 1048576;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic              cam_frame_done;
  logic              cam_hold;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_grant;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              pix_first;
  logic              pix_last;
  logic              busy;
  logic              done;
  logic              timeout;

  color_scan_sequencer #(
    .ADDR_W(ADDR_W), .NPIX(NPIX), .BASE_ADDR(0), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cam_frame_done(cam_frame_done),
    .cam_hold(cam_hold), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_grant(vga_grant), .fb_addr(fb_addr), .fb_data(fb_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_first(pix_first),
    .pix_last(pix_last), .busy(busy), .done(done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer model: one-cycle read latency, contents fb[i] = i[7:0]
  always @(posedge clk) fb_data <= fb_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor
  int pix_cnt = 0, stream_err = 0, hold_err = 0, vga_err = 0, last_cnt = 0, first_cnt = 0;
  int exp_idx = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (vga_req === 1'b1 && (vga_grant !== 1'b1 || fb_addr !== vga_addr)) vga_err++;
    if (pix_valid === 1'b1) begin
      if (pix_data !== exp_idx[7:0] || pix_first !== (exp_idx == 0) ||
          pix_last !== (exp_idx == NPIX - 1)) stream_err++;
      if (cam_hold !== 1'b1) hold_err++;
      pix_cnt++;
      if (pix_first === 1'b1) begin first_cyc = cyc; first_cnt++; end
      if (pix_last === 1'b1) begin last_cyc = cyc; last_cnt++; end
      exp_idx = (exp_idx == NPIX - 1) ? 0 : exp_idx + 1;
    end
    if (done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
    prev_done = done;
  end

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base, lbase, fbase, k, t0, dur;

  initial begin
    rst = 1'b1; start = 1'b0; cam_frame_done = 1'b0; vga_req = 1'b0; vga_addr = 15'h1234;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hold", 32'(cam_hold), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_flags", 32'({pix_first, pix_last}), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'h1234);
    rst = 1'b0;
    tick();

`ifndef SCAN_TIMEOUT_EN
    // Pass 1: no VGA traffic, a stray start pulse mid-scan
    start = 1'b1; tick(); start = 1'b0;
    chk("p1_busy_after_start", 32'(busy), 32'd1);
    chk("p1_hold_in_wait", 32'(cam_hold), 32'd0);
    repeat (4) tick();
    cam_frame_done = 1'b1; tick(); cam_frame_done = 1'b0;
    chk("p1_hold_in_scan", 32'(cam_hold), 32'd1);
    base = pix_cnt; lbase = last_cnt; fbase = first_cnt; k = 0;
    while (done !== 1'b1 && k < 25000) begin
      start = (k == 1000);
      tick();
      k++;
    end
    start = 1'b0;
    @(negedge clk); #1;
    chk("p1_done", 32'(done), 32'd1);
    chk("p1_busy_low", 32'(busy), 32'd0);
    chk("p1_hold_low", 32'(cam_hold), 32'd0);
    chk("p1_pix_count", 32'(pix_cnt - base), 32'd19200);
    chk("p1_first_count", 32'(first_cnt - fbase), 32'd1);
    chk("p1_last_count", 32'(last_cnt - lbase), 32'd1);
    chk("p1_stream_err", 32'(stream_err), 32'd0);
    chk("p1_hold_err", 32'(hold_err), 32'd0);
    chk("p1_no_gaps", 32'(last_cyc - first_cyc), 32'd19199);
    chk("p1_done_after_last", 32'(done_cyc - last_cyc), 32'd1);

    // Pass 2: restart after done, VGA requests every other cycle
    tick();
    chk("p2_done_sticky", 32'(done), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("p2_done_cleared", 32'(done), 32'd0);
    chk("p2_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    cam_frame_done = 1'b1; tick(); cam_frame_done = 1'b0;
    base = pix_cnt; lbase = last_cnt; t0 = cyc; k = 0;
    while (done !== 1'b1 && k < 45000) begin
      vga_req = ~vga_req;
      vga_addr = 15'($urandom_range(0, 32767));
      tick();
      k++;
    end
    vga_req = 1'b0;
    @(negedge clk); #1;
    dur = done_cyc - t0;
    chk("p2_done", 32'(done), 32'd1);
    chk("p2_pix_count", 32'(pix_cnt - base), 32'd19200);
    chk("p2_last_count", 32'(last_cnt - lbase), 32'd1);
    chk("p2_stream_err", 32'(stream_err), 32'd0);
    chk("p2_vga_err", 32'(vga_err), 32'd0);
    chk("p2_duration_approx_38400", 32'(dur >= 38390 && dur <= 38420), 32'd1);

    // Pass 3: reset in the middle of the scan
    tick();
    start = 1'b1; tick(); start = 1'b0;
    cam_frame_done = 1'b1; tick(); cam_frame_done = 1'b0;
    base = pix_cnt; lbase = last_cnt; k = 0;
    while ((pix_cnt - base) < 5000 && k < 6000) begin
      tick();
      k++;
    end
    chk("p3_reached_5000", 32'((pix_cnt - base) >= 5000), 32'd1);
    rst = 1'b1; tick();
    chk("p3_busy", 32'(busy), 32'd0);
    chk("p3_hold", 32'(cam_hold), 32'd0);
    chk("p3_pix_valid", 32'(pix_valid), 32'd0);
    chk("p3_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (50) tick();
    chk("p3_no_last", 32'(last_cnt - lbase), 32'd0);
    chk("p3_no_done", 32'(done), 32'd0);

    // No watchdog: a pass without a frame keeps waiting
    start = 1'b1; tick(); start = 1'b0;
    repeat (200) tick();
    chk("nowd_busy", 32'(busy), 32'd1);
    chk("nowd_timeout", 32'(timeout), 32'd0);
`else
    // Watchdog: no frame arrives, abort after TO_CYC cycles
    start = 1'b1; tick(); start = 1'b0;
    repeat (TO_CYC - 1) tick();
    chk("wd_busy_before", 32'(busy), 32'd1);
    chk("wd_timeout_before", 32'(timeout), 32'd0);
    tick();
    chk("wd_busy_after", 32'(busy), 32'd0);
    chk("wd_timeout_after", 32'(timeout), 32'd1);
    chk("wd_done", 32'(done), 32'd0);
    chk("wd_hold", 32'(cam_hold), 32'd0);
    tick();
    chk("wd_timeout_sticky", 32'(timeout), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("wd_timeout_cleared", 32'(timeout), 32'd0);
    chk("wd_busy_restart", 32'(busy), 32'd1);
    rst = 1'b1; tick();
    chk("wd_rst_busy", 32'(busy), 32'd0);
    chk("wd_rst_timeout", 32'(timeout), 32'd0);
    chk("wd_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
